// File: rtl/sr_ctrl_pkg.sv
// sr_ctrl_pkg: shared state encoding and op constants for the SR flop controller
package sr_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_e;
  localparam logic OP_CLR = 1'b0;
  localparam logic OP_SET = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr modulo N_REQ
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         winner,
  output logic                     valid
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] idx;
  // walk downward so the candidate closest to ptr is assigned last and wins
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) winner = N_REQ'(1) << idx;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/sr_ff_ctrl.sv
// sr_ff_ctrl: arbitrates N_REQ requesters onto one shared SR flop and checks its q feedback
module sr_ff_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op,
  input  logic             q_fb,
  input  logic             err_clr,
  output logic             s,
  output logic             r,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             err
);
  localparam int PW = $clog2(N_REQ);
  state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d, win_idx;
  logic op_q, op_d, s_q, s_d, r_q, r_d, err_q, err_d, win_vld;
  logic [N_REQ-1:0] gnt_q, gnt_d, win;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req),
    .ptr(ptr_q),
    .winner(win),
    .valid(win_vld)
  );
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) if (win[i]) win_idx = PW'(i);
  end
  // s/r/gnt are registered, so they are computed one state ahead of when they appear
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    op_d = op_q;
    s_d = 1'b0;
    r_d = 1'b0;
    gnt_d = '0;
    err_d = err_q & ~err_clr;
    case (state_q)
      IDLE: if (win_vld) begin
        state_d = DRIVE;
        idx_d = win_idx;
        op_d = op[win_idx];
        s_d = op[win_idx] == OP_SET;
        r_d = op[win_idx] == OP_CLR;
      end
      DRIVE: begin
        state_d = CHECK;
        gnt_d = N_REQ'(1) << idx_q;
      end
      CHECK: begin
        state_d = IDLE;
        ptr_d = idx_q == PW'(N_REQ - 1) ? '0 : idx_q + PW'(1);
        err_d = err_d | (q_fb != op_q);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      op_q <= OP_CLR;
      s_q <= 1'b0;
      r_q <= 1'b0;
      gnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      op_q <= op_d;
      s_q <= s_d;
      r_q <= r_d;
      gnt_q <= gnt_d;
      err_q <= err_d;
    end
  end
  assign s = s_q;
  assign r = r_q;
  assign gnt = gnt_q;
  assign busy = state_q != IDLE;
  assign err = err_q;
endmodule

// File: tb/tb_sr_ff_ctrl.sv
// tb_sr_ff_ctrl: drives sr_ff_ctrl against a behavioural SR flop and a transaction-level reference model
module tb_sr_ff_ctrl;
  localparam int N = 4;
  logic clk = 1'b1, reset = 1'b1;
  logic [N-1:0] req = '0, op = '0, gnt, pend = '0, pop = '0;
  logic err_clr = 1'b0, force0 = 1'b0, q_flop, q_fb, s, r, busy, err;
  int total = 0, bad = 0;
  int m_phase, m_ptr, m_win, m_wait[N];
  logic m_op, m_q, m_err;
  logic [N-1:0] gq[$];
  logic qq[$];
  logic [N-1:0] exp_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic exp_q[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) q_flop <= 1'b0;
    else if (s) q_flop <= 1'b1;
    else if (r) q_flop <= 1'b0;
  assign q_fb = force0 ? 1'b0 : q_flop;

  sr_ff_ctrl #(.N_REQ(N)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .q_fb(q_fb), .err_clr(err_clr),
    .s(s), .r(r), .gnt(gnt), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_win = 0; m_op = 1'b0; m_q = 1'b0; m_err = 1'b0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  // phase: 0 waiting for a request, 1 flop being driven, 2 result checked and granted
  task automatic check_outputs();
    chk("s", s, m_phase == 1 && m_op);
    chk("r", r, m_phase == 1 && !m_op);
    chk("gnt", gnt, m_phase == 2 ? (32'd1 << m_win) : 32'd0);
    chk("busy", busy, m_phase != 0);
    chk("err", err, m_err);
    chk("s_and_r", s & r, 0);
    chk("gnt_onehot0", $onehot0(gnt), 1);
  endtask

  task automatic model_next();
    logic mism;
    mism = 1'b0;
    for (int i = 0; i < N; i++) if (!req[i]) m_wait[i] = 0;
    if (m_phase == 2) begin
      mism = (force0 ? 1'b0 : m_q) != m_op;
      for (int i = 0; i < N; i++)
        if (i != m_win && req[i]) begin
          m_wait[i]++;
          chk("starve", m_wait[i] <= N - 1, 1);
        end
      m_wait[m_win] = 0;
    end
    m_err = mism | (m_err & !err_clr);
    case (m_phase)
      0: if (req != 0) begin
        for (int k = 0; k < N; k++) begin
          int cand;
          cand = (m_ptr + k) % N;
          if (req[cand]) begin
            m_win = cand;
            break;
          end
        end
        m_op = op[m_win];
        m_phase = 1;
      end
      1: begin
        m_q = m_op;
        m_phase = 2;
      end
      default: begin
        m_ptr = (m_win + 1) % N;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic step(input logic [N-1:0] rq, input logic [N-1:0] o, input logic ec, input logic f0);
    req = rq; op = o; err_clr = ec; force0 = f0;
    model_next();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs();
    #3;
    reset = 1'b0;
    check_outputs();
    // single set transaction from requester 0
    step(4'b0001, 4'b0001, 1'b0, 1'b0);
    chk("t1_s", s, 1);
    chk("t1_r", r, 0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("t1_qfb", q_fb, 1);
    chk("t1_gnt", gnt, 4'b0001);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("t1_err", err, 0);
    chk("t1_busy", busy, 0);
    // all requesting, alternating ops, ptr wraps
    do_reset();
    for (int c = 0; c < 15; c++) begin
      step(4'b1111, 4'b1010, 1'b0, 1'b0);
      if (gnt != 0) begin
        gq.push_back(gnt);
        qq.push_back(q_fb);
      end
    end
    chk("order_cnt", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      chk("order_gnt", gq[i], exp_g[i]);
      chk("order_q", qq[i], exp_q[i]);
    end
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    // q_fb held low during a set: sticky err, then cleared
    step(4'b0100, 4'b0100, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("mis_err_set", err, 1);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("mis_err_hold", err, 1);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("mis_err_clr", err, 0);
    // reset in DRIVE aborts; pending requests re-arbitrate from ptr 0
    step(4'b1100, 4'b1100, 1'b0, 1'b0);
    chk("abort_pre_s", s, 1);
    reset = 1'b1;
    #1;
    chk("abort_s", s, 0);
    chk("abort_r", r, 0);
    chk("abort_gnt", gnt, 0);
    chk("abort_busy", busy, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    step(4'b1100, 4'b1100, 1'b0, 1'b0);
    step(4'b1100, 4'b1100, 1'b0, 1'b0);
    chk("abort_regnt", gnt, 4'b0100);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    // random traffic with requesters that hold until granted
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && m_phase == 2 && m_win == i) pend[i] = 1'b0;
        else if (pend[i] && $urandom_range(0, 39) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pop[i] = 1'($urandom_range(0, 1));
        end
      end
      step(pend, pop, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
